// File: rtl/wb_la_initiator_if.sv
// Command/response handshake plus Wishbone classic master signals of wb_la_initiator.
// The master modport is the initiator's view; slave is the requester/bus-model view.
interface wb_la_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_la_initiator.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle, one response out,
// with an optional ACK timeout and completed/aborted transaction counters.
module wb_la_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_la_initiator_if.master    bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count,
    output logic [CNT_W-1:0]     err_count
);

    // Wait counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitMax =
        WaitW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   done_q, done_d;
    logic [CNT_W-1:0]   err_q, err_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            wait_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        wait_d    = wait_q;
        done_d    = done_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = StBus;
                    we_d    = bus.cmd_we;
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    sel_d   = bus.cmd_sel;
                    wait_d  = '0;
                end
            end
            StBus: begin
                // ACK takes priority over a timeout falling on the same edge.
                if (bus.wbm_ack_i) begin
                    state_d   = StResp;
                    rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
                    rsp_err_d = 1'b0;
                    done_d    = done_q + 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_q == WaitMax)) begin
                    state_d   = StResp;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    err_d     = err_q + 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = (state_q == StBus);
    assign bus.wbm_stb_o = (state_q == StBus);
    assign bus.wbm_we_o  = (state_q == StBus) && we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;

    assign busy       = (state_q != StIdle);
    assign done_count = done_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_wb_la_initiator.sv
// Directed self-checking bench for wb_la_initiator (built with TIMEOUT_CYCLES=4).
module tb_wb_la_initiator;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] done_count;
    logic [15:0] err_count;
    int          checks;
    int          errors;

    wb_la_initiator_if bus ();

    wb_la_initiator #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .busy      (busy),
        .done_count(done_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for a single edge; afterwards the DUT should be in BUS.
    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_adr   = adr;
        bus.cmd_dat   = dat;
        bus.cmd_sel   = sel;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_dat   = 32'h5555_AAAA;
        bus.cmd_adr   = 32'hFFFF_0000;
    endtask

    // Slave model: ACK on STB cycle ack_at (0 = never). Counts STB cycles and cycles where the
    // bus outputs differ from the expected command.
    task automatic bus_phase(input int ack_at, input logic [31:0] rdata,
                             input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output int stb_cycles, output int held_bad);
        stb_cycles = 0;
        held_bad   = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wbm_stb_o !== 1'b1) break;
            stb_cycles++;
            if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
                bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel || bus.cmd_ready !== 1'b0)
                held_bad++;
            bus.wbm_ack_i = (stb_cycles == ack_at);
            bus.wbm_dat_i = (stb_cycles == ack_at) ? rdata : 32'hBAD0_BAD0;
            step();
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'hBAD0_BAD0;
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0 ||
            bus.wbm_stb_o !== 1'b0 || bus.wbm_we_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy=%b rv=%b cyc=%b stb=%b we=%b busy=%b, want 1 0 0 0 0 0",
                     bus.cmd_ready, bus.rsp_valid, bus.wbm_cyc_o, bus.wbm_stb_o,
                     bus.wbm_we_o, busy);
        end
        checks++;
        if (done_count !== 16'd0 || err_count !== 16'd0 || bus.wbm_adr_o !== 32'h0 ||
            bus.rsp_dat !== 32'h0 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: done=%0d err=%0d adr=%h rdat=%h rerr=%b, want all 0",
                     done_count, err_count, bus.wbm_adr_o, bus.rsp_dat, bus.rsp_err);
        end
    endtask

    task automatic test_write();
        int n, bad;
        send_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (busy !== 1'b1 || bus.wbm_we_o !== 1'b1) begin
            errors++;
            $display("FAIL write_start: busy=%b we=%b, want 1 1", busy, bus.wbm_we_o);
        end
        bus_phase(3, 32'hFFFF_FFFF, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, n, bad);
        checks++;
        if (n !== 3 || bad !== 0) begin
            errors++;
            $display("FAIL write_stb: stb_cycles=%0d held_bad=%0d, want 3 0", n, bad);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'h0 ||
            bus.wbm_cyc_o !== 1'b0 || bus.wbm_we_o !== 1'b0 || done_count !== 16'd1) begin
            errors++;
            $display("FAIL write_rsp: rv=%b err=%b dat=%h cyc=%b we=%b done=%0d, want 1 0 0 0 0 1",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_dat, bus.wbm_cyc_o, bus.wbm_we_o,
                     done_count);
        end
        checks++;
        if (bus.wbm_adr_o !== 32'h3000_0004 || bus.wbm_dat_o !== 32'hDEAD_BEEF ||
            bus.wbm_sel_o !== 4'hF) begin
            errors++;
            $display("FAIL write_idle_hold: adr=%h dat=%h sel=%h, want 30000004 deadbeef f",
                     bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o);
        end
        accept_rsp();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_accept: rdy=%b rv=%b busy=%b, want 1 0 0",
                     bus.cmd_ready, bus.rsp_valid, busy);
        end
    endtask

    task automatic test_read();
        int n, bad;
        send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'h3);
        bus_phase(1, 32'h1234_5678, 1'b0, 32'h3000_0000, 32'h0, 4'h3, n, bad);
        checks++;
        if (n !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL read_stb: stb_cycles=%0d held_bad=%0d, want 1 0", n, bad);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'h1234_5678 || bus.rsp_err !== 1'b0 ||
            done_count !== 16'd2) begin
            errors++;
            $display("FAIL read_rsp: rv=%b dat=%h err=%b done=%0d, want 1 12345678 0 2",
                     bus.rsp_valid, bus.rsp_dat, bus.rsp_err, done_count);
        end
        // A command waiting during response acceptance must not start a cycle that edge.
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        accept_rsp();
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_no_overlap: cyc=%b rdy=%b, want 0 1",
                     bus.wbm_cyc_o, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int n, bad;
        send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        bus_phase(0, 32'h0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, n, bad);
        checks++;
        if (n !== 4 || bad !== 0) begin
            errors++;
            $display("FAIL timeout_stb: stb_cycles=%0d held_bad=%0d, want 4 0", n, bad);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_dat !== 32'h0 ||
            err_count !== 16'd1 || done_count !== 16'd2) begin
            errors++;
            $display("FAIL timeout_rsp: rv=%b err=%b dat=%h errcnt=%0d done=%0d, want 1 1 0 1 2",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_dat, err_count, done_count);
        end
        accept_rsp();
    endtask

    task automatic test_ack_at_limit();
        int n, bad;
        send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h1);
        bus_phase(4, 32'hCAFE_F00D, 1'b0, 32'h3000_0020, 32'h0, 4'h1, n, bad);
        checks++;
        if (n !== 4 || bad !== 0) begin
            errors++;
            $display("FAIL limit_stb: stb_cycles=%0d held_bad=%0d, want 4 0", n, bad);
        end
        checks++;
        if (bus.rsp_err !== 1'b0 || bus.rsp_dat !== 32'hCAFE_F00D || err_count !== 16'd1 ||
            done_count !== 16'd3) begin
            errors++;
            $display("FAIL limit_rsp: err=%b dat=%h errcnt=%0d done=%0d, want 0 cafef00d 1 3",
                     bus.rsp_err, bus.rsp_dat, err_count, done_count);
        end
        accept_rsp();
    endtask

    task automatic test_backpressure();
        int n, bad;
        send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        bus_phase(1, 32'hA5A5_0001, 1'b0, 32'h3000_0030, 32'h0, 4'hF, n, bad);
        for (int i = 0; i < 10; i++) begin
            bus.wbm_ack_i = i[0];
            bus.wbm_dat_i = 32'h0BAD_0000 + i;
            bus.cmd_valid = ~i[0];
            step();
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== 32'hA5A5_0001 || bus.rsp_err !== 1'b0 ||
                bus.cmd_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || done_count !== 16'd4 ||
                err_count !== 16'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rv=%b dat=%h err=%b rdy=%b cyc=%b done=%0d errcnt=%0d, want 1 a5a50001 0 0 0 4 1",
                         i, bus.rsp_valid, bus.rsp_dat, bus.rsp_err, bus.cmd_ready,
                         bus.wbm_cyc_o, done_count, err_count);
            end
        end
        bus.wbm_ack_i = 1'b0;
        bus.cmd_valid = 1'b0;
        accept_rsp();
        checks++;
        if (bus.cmd_ready !== 1'b1 || done_count !== 16'd4) begin
            errors++;
            $display("FAIL bp_release: rdy=%b done=%0d, want 1 4", bus.cmd_ready, done_count);
        end
    endtask

    task automatic test_reset_mid_bus();
        int n, bad;
        send_cmd(1'b1, 32'h3000_0040, 32'h1111_2222, 4'hF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            bus.rsp_valid !== 1'b0 || done_count !== 16'd0 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: cyc=%b stb=%b rdy=%b rv=%b done=%0d errcnt=%0d, want 0 0 1 0 0 0",
                     bus.wbm_cyc_o, bus.wbm_stb_o, bus.cmd_ready, bus.rsp_valid,
                     done_count, err_count);
        end
        send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hC);
        bus_phase(2, 32'h0F0F_7777, 1'b0, 32'h3000_0008, 32'h0, 4'hC, n, bad);
        checks++;
        if (n !== 2 || bad !== 0 || bus.rsp_dat !== 32'h0F0F_7777 || bus.rsp_err !== 1'b0 ||
            done_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_after_read: stb=%0d bad=%0d dat=%h err=%b done=%0d, want 2 0 0f0f7777 0 1",
                     n, bad, bus.rsp_dat, bus.rsp_err, done_count);
        end
        accept_rsp();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_adr   = 32'h0;
        bus.cmd_dat   = 32'h0;
        bus.cmd_sel   = 4'h0;
        bus.rsp_ready = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;

        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_limit();
        test_backpressure();
        test_reset_mid_bus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
